// File: rtl/fact_unit_pkg.sv
// Shared definitions for the factorial engine.
// FSM encodings and the default datapath width.
package fact_unit_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fact_unit_mul.sv
// One multiply step of the factorial loop.
// Returns the truncated product and whether the upper half is nonzero.
module fact_mul
  import fact_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic              ovf
);

  logic [2*DATA_W-1:0] prod;

  assign prod = a * b;
  assign lo   = prod[DATA_W-1:0];
  assign ovf  = |prod[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/fact_unit.sv
// Iterative factorial engine with a 4-phase FACT/FACT_END handshake.
// FACT_EARLY_OVF_EN: saturate and finish on the first overflowing step.
module fact_unit
  import fact_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FACT,
  input  logic [DATA_W-1:0] OPERAND,
  output logic [DATA_W-1:0] RESULT,
  output logic              FACT_END,
  output logic              BUSY,
  output logic              OVF
);

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] cnt;
  logic              ovf_int;
  logic [DATA_W-1:0] prod_lo;
  logic              prod_ovf;

  fact_mul #(.DATA_W(DATA_W)) u_mul (
    .a   (acc),
    .b   (cnt),
    .lo  (prod_lo),
    .ovf (prod_ovf)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      RESULT   <= '0;
      FACT_END <= 1'b0;
      BUSY     <= 1'b0;
      OVF      <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      ovf_int  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (FACT) begin
            state   <= CALC;
            BUSY    <= 1'b1;
            acc     <= DATA_W'(1);
            cnt     <= OPERAND;
            ovf_int <= 1'b0;
          end
        end
        CALC: begin
          // FACT dropping mid-run is an abort: outputs keep old values
          if (!FACT) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else if (cnt <= DATA_W'(1)) begin
            state    <= DONE;
            RESULT   <= acc;
            OVF      <= ovf_int;
            FACT_END <= 1'b1;
`ifdef FACT_EARLY_OVF_EN
          end else if (prod_ovf) begin
            state    <= DONE;
            RESULT   <= '1;
            OVF      <= 1'b1;
            FACT_END <= 1'b1;
`endif
          end else begin
            acc     <= prod_lo;
            cnt     <= cnt - DATA_W'(1);
            ovf_int <= ovf_int | prod_ovf;
          end
        end
        DONE: begin
          if (!FACT) begin
            state    <= IDLE;
            FACT_END <= 1'b0;
            BUSY     <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          FACT_END <= 1'b0;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fact_unit.sv
// Self-checking bench for fact_unit: directed handshake cases
// plus random operands against an exact-arithmetic factorial model.
module tb_fact_unit;

  logic        clk;
  logic        rst;
  logic        fact;
  logic [15:0] operand;
  logic [15:0] result;
  logic        fact_end;
  logic        busy;
  logic        ovf;

  int errs;
  int checks;

  fact_unit #(.DATA_W(16)) dut (
    .CLK      (clk),
    .RST      (rst),
    .FACT     (fact),
    .OPERAND  (operand),
    .RESULT   (result),
    .FACT_END (fact_end),
    .BUSY     (busy),
    .OVF      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // n! from exact arithmetic; "big" marks the first factor that
  // pushes the true product past 16 bits.
  function automatic void ref_fact(input int n, output logic [15:0] res,
                                   output logic o, output int lat);
    longint unsigned ex;
    longint unsigned md;
    int              steps;
    int              first_big;
    ex = 1;
    md = 1;
    steps = 0;
    first_big = 0;
    for (int k = n; k > 1; k--) begin
      steps++;
      md = (md * longint'(k)) % 65536;
      if (first_big == 0) begin
        ex = ex * longint'(k);
        if (ex >= 65536) first_big = steps;
      end
    end
    res = md[15:0];
    o   = (first_big != 0);
    lat = (n <= 1) ? 1 : n;
`ifdef FACT_EARLY_OVF_EN
    if (first_big != 0) begin
      res = 16'hFFFF;
      lat = first_big;
    end
`endif
  endfunction

  logic [15:0] last_res;
  logic        last_ovf;

  task automatic do_run(input int n, output int lat, output bit busy_ok);
    @(negedge clk);
    fact    = 1'b1;
    operand = 16'(n);
    @(posedge clk);
    #1;
    operand = 16'($urandom);
    busy_ok = busy;
    lat     = 0;
    while (!fact_end && lat < 300) begin
      @(posedge clk);
      lat++;
      #1;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic check_run(input string tag, input int n);
    int          lat;
    int          elat;
    bit          bok;
    logic [15:0] eres;
    logic        eovf;
    ref_fact(n, eres, eovf, elat);
    do_run(n, lat, bok);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_res"}, result, eres);
    chk({tag, "_ovf"}, ovf, eovf);
    chk({tag, "_busy"}, bok, 1);
    last_res = eres;
    last_ovf = eovf;
  endtask

  task automatic drop(input string tag);
    @(negedge clk);
    fact = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_end_lo"}, fact_end, 0);
    chk({tag, "_busy_lo"}, busy, 0);
  endtask

  initial begin
    bit saw_end;
    errs    = 0;
    checks  = 0;
    fact    = 1'b0;
    operand = '0;
    rst     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res", result, 0);
    chk("rst_end", fact_end, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b1;

    check_run("n5", 5);
    chk("n5_res_lit", result, 16'h0078);
    drop("n5");
    check_run("n0", 0);
    drop("n0");
    check_run("n1", 1);
    drop("n1");
    check_run("n8", 8);
    chk("n8_res_lit", result, 16'h9D80);
    drop("n8");
    check_run("n9", 9);
    drop("n9");

    // abort after two CALC cycles
    @(negedge clk);
    fact    = 1'b1;
    operand = 16'd6;
    repeat (3) @(posedge clk);
    @(negedge clk);
    fact = 1'b0;
    saw_end = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (fact_end) saw_end = 1'b1;
    end
    chk("abort_end", saw_end, 0);
    chk("abort_busy", busy, 0);
    chk("abort_res", result, last_res);
    chk("abort_ovf", ovf, last_ovf);

    // hold FACT past FACT_END, then a one-cycle low gap
    check_run("hs4", 4);
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("hs_hold_end", fact_end, 1);
      chk("hs_hold_res", result, 16'd24);
    end
    drop("hs");
    check_run("hs3", 3);
    chk("hs3_lit", result, 16'h0006);
    drop("hs3");

    // async reset between clock edges mid-CALC
    @(negedge clk);
    fact    = 1'b1;
    operand = 16'd7;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_res", result, 0);
    chk("arst_end", fact_end, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ovf", ovf, 0);
    fact = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_run("post_rst", 4);
    drop("post_rst");

    for (int i = 0; i < 30; i++) begin
      check_run("rnd", int'($urandom_range(40, 0)));
      drop("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
